mdu: RTL and testbench

Multiply/divide unit for the Execute stage of the five-stage pipelined CPU. It sits beside the ALU and shares the same forwarded `SrcA`/`SrcB` operands. It owns the HI/LO registers and runs multi-cycle multiply and divide operations. Its `MDUResult` (for MFHI/MFLO) is muxed with `ALUResult` into the E/M pipeline register, and `Start`/`Busy` drive the hazard unit's stall logic.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_core.sv | 64 ++++++
 rtl/mdu.sv | 82 ++++++++
 tb/tb_mdu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, default latencies and decode helpers.
// MDU_MADD_EN enables the MADD/MADDU accumulate opcodes.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit for a busy period and write HI/LO at completion.
    function automatic logic is_long_op(input logic [3:0] op);
        logic hit;
        hit = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
        hit = hit || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath of the MDU: next {HI,LO} for a multiply, divide or accumulate.
// MADD/MADDU adders exist only when MDU_MADD_EN is defined.
module mdu_core
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the 32x32 signed product.
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'b0, src_a} * {32'b0, src_b};

    assign div_zero   = (src_b == 32'b0);
    assign signed_div = (op == MDU_DIV);
    assign neg_a      = signed_div && src_a[31];
    assign neg_b      = signed_div && src_b[31];

    // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000, which is its correct magnitude.
    assign dividend = neg_a ? -src_a : src_a;
    assign divisor  = div_zero ? 32'd1 : (neg_b ? -src_b : src_b);
    assign quo      = dividend / divisor;
    assign rem      = dividend % divisor;
    assign quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_fix  = neg_a ? -rem : rem;

    always_comb begin
        result = 64'b0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV,
            MDU_DIVU:  result = {rem_fix, quo_fix};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = {hi, lo} + prod_s;
            MDU_MADDU: result = {hi, lo} + prod_u;
`endif
            default:   result = 64'b0;
        endcase
    end

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, sequences multi-cycle ops, drives Start/Busy.
// Build with MDU_MADD_EN to add MADD/MADDU.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUOp,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDUResult
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      hi_n;
    logic [31:0]      lo_n;
    logic             dz_n;
    logic [63:0]      core_result;
    logic             core_div_zero;
    logic             idle_op;

    mdu_core u_core (
        .op       (MDUOp),
        .src_a    (SrcA),
        .src_b    (SrcB),
        .hi       (hi),
        .lo       (lo),
        .result   (core_result),
        .div_zero (core_div_zero)
    );

    assign Busy    = (cnt != '0);
    assign idle_op = en && !Busy;
    assign Start   = idle_op && is_long_op(MDUOp);

    // NOTE: shadow registers are reset as well, so an op discarded by reset can never reach HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            hi   <= 32'b0;
            lo   <= 32'b0;
            hi_n <= 32'b0;
            lo_n <= 32'b0;
            dz_n <= 1'b0;
        end else begin
            if (Start) begin
                cnt  <= is_div_op(MDUOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                hi_n <= core_result[63:32];
                lo_n <= core_result[31:0];
                dz_n <= is_div_op(MDUOp) && core_div_zero;
            end else if (Busy) begin
                cnt <= cnt - CNT_W'(1);
            end

            if ((cnt == CNT_W'(1)) && !dz_n) begin
                hi <= hi_n;
                lo <= lo_n;
            end

            if (idle_op && (MDUOp == MDU_MTHI)) hi <= SrcA;
            if (idle_op && (MDUOp == MDU_MTLO)) lo <= SrcA;
        end
    end

    always_comb begin
        MDUResult = 32'b0;
        if (MDUOp == MDU_MFHI)      MDUResult = hi;
        else if (MDUOp == MDU_MFLO) MDUResult = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized traffic against an arithmetic model.
// Honors MDU_MADD_EN the same way as the design.
module tb_mdu;
    import mdu_pkg::*;

    localparam int LAT_MUL = 5;
    localparam int LAT_DIV = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUResult;

    always #5 clk = ~clk;

    mdu dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .MDUOp     (MDUOp),
        .Start     (Start),
        .Busy      (Busy),
        .MDUResult (MDUResult)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: architectural HI/LO, pending result and remaining busy cycles.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dz;
    int          m_rem;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_long(input logic [3:0] op);
        logic r;
        r = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
        r = r || (op == 4'd9) || (op == 4'd10);
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_dz = 0; m_rem = 0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && !m_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (e) begin
            if (op == 4'd7) m_hi = a;
            if (op == 4'd8) m_lo = a;
            if (m_long(op)) begin
                p = 64'b0;
                m_dz = 1'b0;
                case (op)
                    4'd1: p = sa * sb;
                    4'd2: p = ua * ub;
                    4'd3, 4'd4: begin
                        if (b == 32'b0) m_dz = 1'b1;
                        else begin
                            q = (op == 4'd3) ? sa / sb : ua / ub;
                            r = (op == 4'd3) ? sa % sb : ua % ub;
                            p = {r[31:0], q[31:0]};
                        end
                    end
                    4'd9:  p = {m_hi, m_lo} + 64'(sa * sb);
                    4'd10: p = {m_hi, m_lo} + 64'(ua * ub);
                    default: p = 64'b0;
                endcase
                p_hi  = p[63:32];
                p_lo  = p[31:0];
                m_rem = ((op == 4'd3) || (op == 4'd4)) ? LAT_DIV : LAT_MUL;
            end
        end
    endtask

    // One clock: drive, check outputs mid-cycle against the model, step the model on the edge.
    task automatic cycle(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        en = e; MDUOp = op; SrcA = a; SrcB = b;
        #1;
        exp_res = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'b0;
        check("start", Start, e && (m_rem == 0) && m_long(op));
        check("busy", Busy, m_rem != 0);
        check("result", MDUResult, exp_res);
        @(posedge clk);
        model_edge(e, op, a, b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input logic [3:0] hold_op, output int n);
        n = 0;
        while (Busy && n < 100) begin
            cycle(1'b1, hold_op, 32'b0, 32'b0);
            n++;
        end
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        en = 1'b1; MDUOp = MDU_MFHI;
        #1 check({tag, "_hi"}, MDUResult, h);
        cycle(1'b1, MDU_MFHI, 32'b0, 32'b0);
        MDUOp = MDU_MFLO;
        #1 check({tag, "_lo"}, MDUResult, l);
        cycle(1'b1, MDU_MFLO, 32'b0, 32'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h2, 32'h7};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        reset_n = 1'b0; en = 1'b0; MDUOp = MDU_MFHI; SrcA = 0; SrcB = 0;
        model_reset();
        #12;
        check("reset_busy", Busy, 1'b0);
        check("reset_start", Start, 1'b0);
        check("reset_hi", MDUResult, 32'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // MULT / MULTU with busy-period length
        cycle(1'b1, MDU_MULT, 32'hFFFF_FFFF, 32'h2);
        wait_idle(MDU_MFLO, n);
        check("mult_busy_cycles", n, LAT_MUL);
        en = 1'b1; MDUOp = MDU_MFLO;
        #1 check("mflo_after_stall", MDUResult, 32'hFFFF_FFFE);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        cycle(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
        cycle(1'b1, MDU_MTLO, 32'h1234, 32'b0);
        wait_idle(MDU_NONE, n);
        expect_hilo("multu", 32'h1, 32'hFFFF_FFFE);

        // Signed divide, overflow corner, divide by zero
        cycle(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_idle(MDU_NONE, n);
        check("div_busy_cycles", n, LAT_DIV);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        cycle(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(MDU_NONE, n);
        expect_hilo("div_ovf", 32'h0, 32'h8000_0000);
        cycle(1'b1, MDU_MTHI, 32'h11, 32'b0);
        cycle(1'b1, MDU_MTLO, 32'h22, 32'b0);
        cycle(1'b1, MDU_DIVU, 32'h7, 32'h0);
        wait_idle(MDU_NONE, n);
        check("divz_busy_cycles", n, LAT_DIV);
        expect_hilo("divz", 32'h11, 32'h22);

        // MTHI/MFHI and disabled slot
        cycle(1'b1, MDU_MTHI, 32'hDEAD_BEEF, 32'b0);
        en = 1'b1; MDUOp = MDU_MFHI;
        #1 check("mthi_mfhi", MDUResult, 32'hDEAD_BEEF);
        cycle(1'b0, MDU_MTHI, 32'h5, 32'b0);
        expect_hilo("en_low", 32'hDEAD_BEEF, 32'h22);

        // Accumulate, or its absence
`ifdef MDU_MADD_EN
        cycle(1'b1, MDU_MTHI, 32'h0, 32'b0);
        cycle(1'b1, MDU_MTLO, 32'hFFFF_FFFF, 32'b0);
        cycle(1'b1, MDU_MADDU, 32'h1, 32'h1);
        wait_idle(MDU_NONE, n);
        check("maddu_busy_cycles", n, LAT_MUL);
        expect_hilo("maddu", 32'h1, 32'h0);
`else
        en = 1'b1; MDUOp = MDU_MADD; SrcA = 32'h3; SrcB = 32'h4;
        #1 check("op9_start", Start, 1'b0);
        cycle(1'b1, MDU_MADD, 32'h3, 32'h4);
        cycle(1'b1, MDU_MADDU, 32'h3, 32'h4);
        check("op9_busy", Busy, 1'b0);
        expect_hilo("no_madd", 32'hDEAD_BEEF, 32'h22);
`endif

        // Reset in the middle of a divide
        cycle(1'b1, MDU_DIV, 32'h64, 32'h3);
        cycle(1'b1, MDU_NONE, 32'b0, 32'b0);
        cycle(1'b1, MDU_NONE, 32'b0, 32'b0);
        en = 1'b1; MDUOp = MDU_MFHI;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_busy", Busy, 1'b0);
        check("midreset_hi", MDUResult, 32'b0);
        MDUOp = MDU_MFLO;
        #1 check("midreset_lo", MDUResult, 32'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) cycle(1'b1, MDU_NONE, 32'b0, 32'b0);
        expect_hilo("after_reset", 32'h0, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) != 0, op, rnd_operand(), rnd_operand());
        end
        wait_idle(MDU_NONE, n);
        check("final_idle", Busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
